program_writer: RTL and testbench

Streaming back-end of the toolchain path: accepts decoded `Instruction` structs over a valid/ready handshake, re-encodes each into its 32-bit RV32I word, and writes the words into instruction memory at consecutive word addresses. It is the inverse of the CPU's instruction decoder. It sits between the testbench/loader and the instruction-memory write port, and flags any struct that has no RV32I encoding.

---
 rtl/program_writer_pkg.sv | 62 ++++++
 rtl/instruction_encoder.sv | 81 ++++++++
 rtl/program_writer.sv | 97 +++++++++
 tb/tb_program_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_writer_pkg.sv
// Shared RV32I types and encoding constants used by the program writer and the CPU decoder.
package program_writer_pkg;

  typedef logic [31:0] Immediate;
  typedef logic [4:0]  RegIndex;

  typedef enum logic [1:0] {RD_NONE, RD_ALU, RD_RAM_OUT, RD_NEXT_PC} RdSel;
  typedef enum logic [1:0] {BC_NEVER, BC_ALWAYS, BC_CMP_TRUE, BC_CMP_FALSE} BranchCond;
  typedef enum logic [1:0] {CMP_EQ = 2'b00, CMP_LT = 2'b10, CMP_LTU = 2'b11} CmpOp;
  typedef enum logic [1:0] {ALU1_ZERO, ALU1_PC, ALU1_RS1} Alu1Sel;
  typedef enum logic [0:0] {ALU2_RS2, ALU2_IMM} Alu2Sel;

  // op[2:0] is the RV32I funct3; op[3] selects the SUB/SRA variant.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } AluOp;

  typedef struct packed {
    logic      is_ebreak;
    logic      ram_write;
    RdSel      rd_sel;
    BranchCond branch_cond;
    CmpOp      cmp_op;
    Alu1Sel    alu1_sel;
    Alu2Sel    alu2_sel;
    AluOp      alu_op;
  } Control;

  typedef struct packed {
    Control   control;
    Immediate immediate;
    RegIndex  rs1;
    RegIndex  rs2;
    RegIndex  rd;
  } Instruction;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0]  F3_WORD     = 3'b010;
  localparam logic [2:0]  F3_JALR     = 3'b000;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_WORD = {12'h001, 5'd0, 3'd0, 5'd0, OP_SYSTEM};

endpackage

// File: rtl/instruction_encoder.sv
// Combinational re-encoder: decoded Instruction struct back to its RV32I word.
module instruction_encoder
  import program_writer_pkg::*;
(
  input  Instruction  instr_i,
  output logic [31:0] word_o,
  output logic        invalid_o
);

  Control      ctrl;
  Immediate    imm;
  logic [3:0]  op;
  logic        fit_i, fit_b, fit_j;
  logic        ok;
  logic [31:0] word;

  assign ctrl = instr_i.control;
  assign imm  = instr_i.immediate;
  assign op   = ctrl.alu_op;

  // A field fits when every bit above its sign bit matches the sign bit.
  assign fit_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit_b = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fit_j = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    ok   = 1'b1;
    word = NOP_WORD;
    if (ctrl.is_ebreak) begin
      word = EBREAK_WORD;
    end else if (ctrl.ram_write) begin
      word = {imm[11:5], instr_i.rs2, instr_i.rs1, F3_WORD, imm[4:0], OP_STORE};
      ok   = fit_i;
    end else if (ctrl.rd_sel == RD_RAM_OUT) begin
      word = {imm[11:0], instr_i.rs1, F3_WORD, instr_i.rd, OP_LOAD};
      ok   = fit_i;
    end else if (ctrl.branch_cond == BC_CMP_TRUE || ctrl.branch_cond == BC_CMP_FALSE) begin
      word = {imm[12], imm[10:5], instr_i.rs2, instr_i.rs1, ctrl.cmp_op,
              ctrl.branch_cond == BC_CMP_FALSE, imm[4:1], imm[11], OP_BRANCH};
      ok   = fit_b & (ctrl.cmp_op inside {CMP_EQ, CMP_LT, CMP_LTU});
    end else if (ctrl.branch_cond == BC_ALWAYS) begin
      if (ctrl.rd_sel == RD_NEXT_PC && ctrl.alu1_sel == ALU1_PC) begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], instr_i.rd, OP_JAL};
        ok   = fit_j;
      end else if (ctrl.rd_sel == RD_NEXT_PC && ctrl.alu1_sel == ALU1_RS1) begin
        word = {imm[11:0], instr_i.rs1, F3_JALR, instr_i.rd, OP_JALR};
        ok   = fit_i;
      end else begin
        ok = 1'b0;
      end
    end else if (ctrl.rd_sel == RD_ALU) begin
      if (ctrl.alu1_sel == ALU1_ZERO && ctrl.alu_op == ALU_XOR) begin
        word = {imm[31:12], instr_i.rd, OP_LUI};
        ok   = (imm[11:0] == 12'h000);
      end else if (ctrl.alu1_sel == ALU1_PC && ctrl.alu_op == ALU_ADD) begin
        word = {imm[31:12], instr_i.rd, OP_AUIPC};
        ok   = (imm[11:0] == 12'h000);
      end else if (ctrl.alu1_sel == ALU1_RS1 && ctrl.alu2_sel == ALU2_RS2) begin
        word = {1'b0, op[3], 5'b00000, instr_i.rs2, instr_i.rs1, op[2:0], instr_i.rd, OP_REG};
        ok   = ~op[3] | (ctrl.alu_op == ALU_SUB) | (ctrl.alu_op == ALU_SRA);
      end else if (ctrl.alu1_sel == ALU1_RS1 && ctrl.alu2_sel == ALU2_IMM) begin
        if (op[1:0] == 2'b01) begin
          word = {1'b0, op[3], 5'b00000, imm[4:0], instr_i.rs1, op[2:0], instr_i.rd, OP_IMM};
          ok   = (imm[31:5] == '0) & (~op[3] | (ctrl.alu_op == ALU_SRA));
        end else begin
          // There is no immediate form of SUB, so op[3] is never legal here.
          word = {imm[11:0], instr_i.rs1, op[2:0], instr_i.rd, OP_IMM};
          ok   = fit_i & ~op[3];
        end
      end else begin
        ok = 1'b0;
      end
    end else begin
      ok = 1'b0;
    end
  end

  assign invalid_o = ~ok;
  assign word_o    = ok ? word : NOP_WORD;

endmodule

// File: rtl/program_writer.sv
// Streams decoded instructions into instruction memory as RV32I words at consecutive addresses.
module program_writer
  import program_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  Instruction        in_instr_i,
  input  logic              in_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] error_index_o
);

  typedef enum logic [0:0] {StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] eidx_q, eidx_d;

  logic [31:0] enc_word;
  logic        enc_invalid;
  logic        xfer;

  instruction_encoder u_encoder (
    .instr_i   (in_instr_i),
    .word_o    (enc_word),
    .invalid_o (enc_invalid)
  );

  assign xfer = in_valid_i && (state_q == StLoad);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
    eidx_d  = eidx_q;
    if (xfer) begin
      we_d    = 1'b1;
      addr_d  = count_q[ADDR_W-1:0];
      wdata_d = enc_word;
      count_d = count_q + 1'b1;
      error_d = error_q | enc_invalid;
      if (enc_invalid && !error_q) begin
        eidx_d = count_q[ADDR_W-1:0];
      end
      // The last free slot stops the stream so the address never wraps.
      if (in_last_i || (&count_q[ADDR_W-1:0])) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StLoad;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= NOP_WORD;
      error_q <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
      eidx_q  <= eidx_d;
    end
  end

  assign in_ready_o    = (state_q == StLoad);
  assign done_o        = (state_q == StDone);
  assign imem_we_o     = we_q;
  assign imem_addr_o   = addr_q;
  assign imem_wdata_o  = wdata_q;
  assign count_o       = count_q;
  assign error_o       = error_q;
  assign error_index_o = eidx_q;

endmodule

// File: tb/tb_program_writer.sv
// Scoreboard bench: driver pushes reference words, negedge monitors pop and compare.
module tb_program_writer;
  import program_writer_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, in_last, in_valid_s;
  Instruction in_instr, in_instr_s;

  logic          in_ready, imem_we, done, error;
  logic [AW-1:0] imem_addr, error_index;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  logic           in_ready_s, we_s, done_s, error_s;
  logic [SAW-1:0] addr_s, eidx_s;
  logic [31:0]    wdata_s;
  logic [SAW:0]   count_s;

  program_writer #(.ADDR_W(AW)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_last_i(in_last), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .count_o(count), .done_o(done), .error_o(error),
    .error_index_o(error_index)
  );

  program_writer #(.ADDR_W(SAW)) dut_small (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid_s), .in_ready_o(in_ready_s),
    .in_instr_i(in_instr_s), .in_last_i(1'b0), .imem_we_o(we_s), .imem_addr_o(addr_s),
    .imem_wdata_o(wdata_s), .count_o(count_s), .done_o(done_s), .error_o(error_s),
    .error_index_o(eidx_s)
  );

  typedef struct {
    int unsigned addr;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_sq[$];

  int checks = 0;
  int failures = 0;
  int unsigned m_count = 0, m_eidx = 0, ms_count = 0;
  bit m_done = 0, m_err = 0, ms_done = 0;
  bit mon_en = 0;
  int writes_s = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built directly from the RV32I field layout and numeric ranges.
  function automatic logic [32:0] ref_encode(input Instruction ins);
    Control c = ins.control;
    logic [31:0] imm = ins.immediate;
    longint s = longint'($signed(ins.immediate));
    logic [31:0] r_d = 32'(ins.rd) << 7;
    logic [31:0] r_1 = 32'(ins.rs1) << 15;
    logic [31:0] r_2 = 32'(ins.rs2) << 20;
    logic [31:0] base = 32'(c.alu_op) & 32'h7;
    logic [31:0] alt = (32'(c.alu_op) >> 3) & 32'h1;
    bit in12 = (s >= -2048) && (s <= 2047);
    bit ok = 1'b1;
    logic [31:0] w = 32'h0;
    if (c.is_ebreak) begin
      w = 32'h0010_0073;
    end else if (c.ram_write) begin
      ok = in12;
      w = 32'h23 | 32'h2000 | r_1 | r_2 | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
    end else if (c.rd_sel == RD_RAM_OUT) begin
      ok = in12;
      w = 32'h03 | 32'h2000 | r_d | r_1 | ((imm & 32'hFFF) << 20);
    end else if (c.branch_cond == BC_CMP_TRUE || c.branch_cond == BC_CMP_FALSE) begin
      ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0) && (32'(c.cmp_op) != 32'd1);
      w = 32'h63 | (((32'(c.cmp_op) * 2) + ((c.branch_cond == BC_CMP_FALSE) ? 32'd1 : 32'd0)) << 12)
          | r_1 | r_2 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
          | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
    end else if (c.branch_cond == BC_ALWAYS) begin
      if (c.rd_sel == RD_NEXT_PC && c.alu1_sel == ALU1_PC) begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w = 32'h6F | r_d | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
            | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      end else if (c.rd_sel == RD_NEXT_PC && c.alu1_sel == ALU1_RS1) begin
        ok = in12;
        w = 32'h67 | r_d | r_1 | ((imm & 32'hFFF) << 20);
      end else begin
        ok = 1'b0;
      end
    end else if (c.rd_sel == RD_ALU) begin
      if (c.alu1_sel == ALU1_ZERO && c.alu_op == ALU_XOR) begin
        ok = ((imm & 32'hFFF) == 0);
        w = 32'h37 | r_d | (imm & 32'hFFFF_F000);
      end else if (c.alu1_sel == ALU1_PC && c.alu_op == ALU_ADD) begin
        ok = ((imm & 32'hFFF) == 0);
        w = 32'h17 | r_d | (imm & 32'hFFFF_F000);
      end else if (c.alu1_sel == ALU1_RS1 && c.alu2_sel == ALU2_RS2) begin
        ok = (alt == 0) || (c.alu_op == ALU_SUB) || (c.alu_op == ALU_SRA);
        w = 32'h33 | r_d | (base << 12) | r_1 | r_2 | (alt << 30);
      end else if (c.alu1_sel == ALU1_RS1 && c.alu2_sel == ALU2_IMM) begin
        if (base == 1 || base == 5) begin
          ok = (imm <= 31) && ((alt == 0) || (c.alu_op == ALU_SRA));
          w = 32'h13 | r_d | (base << 12) | r_1 | ((imm & 32'h1F) << 20) | (alt << 30);
        end else begin
          ok = in12 && (alt == 0);
          w = 32'h13 | r_d | (base << 12) | r_1 | ((imm & 32'hFFF) << 20);
        end
      end else begin
        ok = 1'b0;
      end
    end else begin
      ok = 1'b0;
    end
    return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
  endfunction

  function automatic Instruction gen_instr();
    Instruction t;
    logic [31:0] r = $urandom;
    bit wide = ($urandom_range(0, 3) == 0);
    AluOp ops[10] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                      ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA};
    CmpOp cmps[3] = '{CMP_EQ, CMP_LT, CMP_LTU};
    t = '0;
    t.rs1 = 5'($urandom);
    t.rs2 = 5'($urandom);
    t.rd = 5'($urandom);
    t.control.alu_op = ops[$urandom_range(0, 9)];
    t.control.cmp_op = cmps[$urandom_range(0, 2)];
    t.immediate = wide ? r : {{20{r[11]}}, r[11:0]};
    case ($urandom_range(0, 10))
      0: begin t.control.is_ebreak = 1'b1; t.control.ram_write = r[0]; end
      1: t.control.ram_write = 1'b1;
      2: t.control.rd_sel = RD_RAM_OUT;
      3: begin
        t.control.branch_cond = r[20] ? BC_CMP_TRUE : BC_CMP_FALSE;
        t.immediate = wide ? r : {{19{r[12]}}, r[12:1], 1'b0};
      end
      4: begin
        t.control.branch_cond = BC_ALWAYS; t.control.rd_sel = RD_NEXT_PC;
        t.control.alu1_sel = ALU1_PC;
        t.immediate = wide ? r : {{11{r[20]}}, r[20:1], 1'b0};
      end
      5: begin
        t.control.branch_cond = BC_ALWAYS; t.control.rd_sel = RD_NEXT_PC;
        t.control.alu1_sel = ALU1_RS1;
      end
      6, 7: begin
        t.control.rd_sel = RD_ALU;
        t.control.alu1_sel = r[0] ? ALU1_ZERO : ALU1_PC;
        t.control.alu_op = r[0] ? ALU_XOR : ALU_ADD;
        t.immediate = wide ? r : {r[31:12], 12'h000};
      end
      8: begin
        t.control.rd_sel = RD_ALU; t.control.alu1_sel = ALU1_RS1; t.control.alu2_sel = ALU2_RS2;
      end
      9: begin
        t.control.rd_sel = RD_ALU; t.control.alu1_sel = ALU1_RS1; t.control.alu2_sel = ALU2_IMM;
        if (t.control.alu_op[1:0] == 2'b01)
          t.immediate = wide ? 32'($urandom_range(0, 40)) : {27'd0, r[4:0]};
      end
      default: begin
        t.control.rd_sel = RdSel'(r[1:0]);
        t.control.branch_cond = BranchCond'(r[3:2]);
        t.control.alu1_sel = Alu1Sel'(2'($urandom_range(0, 2)));
        t.control.alu2_sel = Alu2Sel'(r[4]);
      end
    endcase
    return t;
  endfunction

  function automatic Instruction mk(input bit ebreak, input bit ramw, input RdSel rds,
                                    input BranchCond bc, input Alu1Sel a1, input Alu2Sel a2,
                                    input AluOp op, input logic [31:0] imm,
                                    input int rs1, input int rs2, input int rd);
    Instruction t;
    t = '0;
    t.control.is_ebreak = ebreak;
    t.control.ram_write = ramw;
    t.control.rd_sel = rds;
    t.control.branch_cond = bc;
    t.control.cmp_op = CMP_EQ;
    t.control.alu1_sel = a1;
    t.control.alu2_sel = a2;
    t.control.alu_op = op;
    t.immediate = imm;
    t.rs1 = 5'(rs1);
    t.rs2 = 5'(rs2);
    t.rd = 5'(rd);
    return t;
  endfunction

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic step(input logic v, input Instruction ins, input logic last, input logic rst,
                      input logic vs, input Instruction ins_s);
    logic [32:0] r;
    reset = rst;
    in_valid = v;
    in_instr = ins;
    in_last = last;
    in_valid_s = vs;
    in_instr_s = ins_s;
    @(posedge clk);
    if (rst) begin
      m_count = 0; m_done = 0; m_err = 0; m_eidx = 0; exp_q.delete();
      ms_count = 0; ms_done = 0; exp_sq.delete();
    end else begin
      if (v && !m_done) begin
        r = ref_encode(ins);
        exp_q.push_back('{m_count, r[31:0]});
        if (r[32] && !m_err) begin
          m_err = 1; m_eidx = m_count;
        end
        m_count++;
        if (last || m_count == (1 << AW)) m_done = 1;
      end
      if (vs && !ms_done) begin
        r = ref_encode(ins_s);
        exp_sq.push_back('{ms_count, r[31:0]});
        ms_count++;
        if (ms_count == (1 << SAW)) ms_done = 1;
      end
    end
    @(negedge clk);
  endtask

  Instruction zero_ins = '0;

  task automatic go(input logic v, input Instruction ins, input logic last);
    step(v, ins, last, 1'b0, 1'b0, zero_ins);
  endtask

  task automatic rst_cycle();
    step(1'b0, zero_ins, 1'b0, 1'b1, 1'b0, zero_ins);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("imem_we", 32'(imem_we), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (imem_we) begin
          check("imem_addr", 32'(imem_addr), e.addr);
          check("imem_wdata", imem_wdata, e.word);
        end
      end
      check("in_ready", 32'(in_ready), 32'(!m_done));
      check("done", 32'(done), 32'(m_done));
      check("count", 32'(count), m_count);
      check("error", 32'(error), 32'(m_err));
      check("error_index", 32'(error_index), m_eidx);
      check("small imem_we", 32'(we_s), 32'(exp_sq.size() != 0));
      if (we_s) writes_s++;
      if (exp_sq.size() != 0) begin
        e = exp_sq.pop_front();
        if (we_s) begin
          check("small imem_addr", 32'(addr_s), e.addr);
          check("small imem_wdata", wdata_s, e.word);
        end
      end
      check("small in_ready", 32'(in_ready_s), 32'(!ms_done));
      check("small count", 32'(count_s), ms_count);
    end
  end

  Instruction addi_m10, lui_i, beq_i, sw_i, ebreak_i, addi_ok, addi_bad, slli_bad;

  initial begin
    addi_m10 = mk(0, 0, RD_ALU, BC_NEVER, ALU1_RS1, ALU2_IMM, ALU_ADD, -32'sd10, 0, 0, 1);
    lui_i    = mk(0, 0, RD_ALU, BC_NEVER, ALU1_ZERO, ALU2_IMM, ALU_XOR, 32'h7FEED000, 0, 0, 1);
    beq_i    = mk(0, 0, RD_NONE, BC_CMP_TRUE, ALU1_PC, ALU2_IMM, ALU_ADD, -32'sd4, 2, 1, 0);
    sw_i     = mk(0, 1, RD_NONE, BC_NEVER, ALU1_RS1, ALU2_IMM, ALU_ADD, 32'h100, 1, 10, 0);
    ebreak_i = mk(1, 0, RD_NONE, BC_NEVER, ALU1_ZERO, ALU2_RS2, ALU_ADD, 32'h0, 0, 0, 0);
    addi_ok  = mk(0, 0, RD_ALU, BC_NEVER, ALU1_RS1, ALU2_IMM, ALU_ADD, 32'd7, 3, 0, 4);
    addi_bad = mk(0, 0, RD_ALU, BC_NEVER, ALU1_RS1, ALU2_IMM, ALU_ADD, 32'd2048, 3, 0, 4);
    slli_bad = mk(0, 0, RD_ALU, BC_NEVER, ALU1_RS1, ALU2_IMM, ALU_SLL, 32'd40, 3, 0, 4);

    rst_cycle();
    rst_cycle();
    mon_en = 1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset imem_we", 32'(imem_we), 32'd0);
    check("reset imem_addr", 32'(imem_addr), 32'd0);
    check("reset imem_wdata", imem_wdata, 32'h0000_0013);
    check("reset count", 32'(count), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset error_index", 32'(error_index), 32'd0);

    go(1, addi_m10, 0);
    check("addi we", 32'(imem_we), 32'd1);
    check("addi addr", 32'(imem_addr), 32'd0);
    check("addi word", imem_wdata, 32'hFF60_0093);
    check("addi count", 32'(count), 32'd1);

    rst_cycle();
    go(1, lui_i, 0);
    check("lui word", imem_wdata, 32'h7FEE_D0B7);
    go(1, beq_i, 0);
    check("beq addr", 32'(imem_addr), 32'd1);
    check("beq word", imem_wdata, 32'hFE11_0EE3);
    go(1, sw_i, 0);
    check("sw word", imem_wdata, 32'h10A0_A023);
    go(1, ebreak_i, 1);
    check("ebreak addr", 32'(imem_addr), 32'd3);
    check("ebreak word", imem_wdata, 32'h0010_0073);
    check("last done", 32'(done), 32'd1);
    check("last in_ready", 32'(in_ready), 32'd0);
    go(1, addi_ok, 0);
    go(1, addi_ok, 0);
    check("done blocks writes", 32'(imem_we), 32'd0);

    rst_cycle();
    repeat (5) go(1, addi_ok, 0);
    go(1, addi_bad, 0);
    check("bad word", imem_wdata, 32'h0000_0013);
    check("bad error", 32'(error), 32'd1);
    check("bad error_index", 32'(error_index), 32'd5);
    go(1, addi_ok, 0);
    go(1, slli_bad, 0);
    check("second bad error_index", 32'(error_index), 32'd5);
    check("second bad count", 32'(count), 32'd8);

    rst_cycle();
    go(1, addi_ok, 0);
    rst_cycle();
    check("rst drop imem_we", 32'(imem_we), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    // Reset and transfer in the same cycle: the transfer must be ignored.
    step(1'b1, addi_ok, 1'b0, 1'b1, 1'b1, addi_ok);
    check("rst+xfer count", 32'(count), 32'd0);

    for (int i = 0; i < 20; i++) go(i % 2 == 0, gen_instr(), 0);
    check("toggle count", 32'(count), 32'd10);

    rst_cycle();
    writes_s = 0;
    for (int i = 0; i < 8; i++) step(1'b0, zero_ins, 1'b0, 1'b0, 1'b1, gen_instr());
    check("small writes", 32'(writes_s), 32'd4);
    check("small done", 32'(done_s), 32'd1);
    check("small in_ready", 32'(in_ready_s), 32'd0);
    check("small count full", 32'(count_s), 32'd4);

    rst_cycle();
    for (int i = 0; i < 400; i++) begin
      if (m_done) rst_cycle();
      else go($urandom_range(0, 2) != 0, gen_instr(), $urandom_range(0, 60) == 0);
    end
    go(0, zero_ins, 0);
    go(0, zero_ins, 0);
    check("drain", 32'(exp_q.size() + exp_sq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
